// File: rtl/img_filter_3x3.sv
// rtl/img_filter_3x3.sv - streaming 3x3 neighbourhood filter (pass / |Gx| / |Gy| / |Gx|+|Gy|)
module img_filter_3x3 #(
  parameter int DW    = 8,
  parameter int IMG_W = 640,
  parameter int XW    = 12,
  parameter int YW    = 16
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic [DW-1:0] iDATA,
  input  logic          iDVAL,
  input  logic [XW-1:0] iX_Cont,
  input  logic [YW-1:0] iY_Cont,
  input  logic [1:0]    iMODE,
  output logic [DW-1:0] oDATA,
  output logic          oDVAL,
  output logic [XW-1:0] oX_Cont,
  output logic [YW-1:0] oY_Cont,
  output logic [1:0]    oMODE
);

  localparam int AW = (IMG_W > 1) ? $clog2(IMG_W) : 1;
  localparam int SW = DW + 3;
  localparam logic [XW-1:0] IMG_W_X = XW'(IMG_W);
  localparam logic [SW:0]   SAT_MAX = {{4{1'b0}}, {DW{1'b1}}};

  // Pixels beyond the active line width are dropped entirely.
  logic          accept;
  logic          frame_start;
  logic          emit;
  logic [AW-1:0] col;

  assign accept      = iDVAL && (iX_Cont < IMG_W_X);
  assign frame_start = accept && (iX_Cont == '0) && (iY_Cont == '0);
  assign emit        = accept && (iX_Cont != '0) && (iY_Cont != '0);
  assign col         = iX_Cont[AW-1:0];

  // Line buffers: lb0 holds the previous row, lb1 the row before it.
  logic [DW-1:0] lb0_mem [IMG_W];
  logic [DW-1:0] lb1_mem [IMG_W];
  logic [DW-1:0] lb0_rd;
  logic [DW-1:0] lb1_rd;

  assign lb0_rd = lb0_mem[col];
  assign lb1_rd = lb1_mem[col];

  // Rotate the column through both line buffers; contents are left unreset.
  always_ff @(posedge clk) begin
    if (accept) begin
      lb1_mem[col] <= lb0_rd;
      lb0_mem[col] <= iDATA;
    end
  end

  // 3x3 window indexed [row][col]; new column enters on the right.
  logic [DW-1:0] win_q [3][3];

  // Shift the window left and load {lb1, lb0, iDATA} as the new right column.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int r = 0; r < 3; r++) begin
        for (int c = 0; c < 3; c++) begin
          win_q[r][c] <= '0;
        end
      end
    end else if (accept) begin
      for (int r = 0; r < 3; r++) begin
        win_q[r][0] <= win_q[r][1];
        win_q[r][1] <= win_q[r][2];
      end
      win_q[0][2] <= lb1_rd;
      win_q[1][2] <= lb0_rd;
      win_q[2][2] <= iDATA;
    end
  end

  // Mode register: only a frame-start pixel may change the active filter.
  logic [1:0] mode_q;

  // Latch the requested mode at the (0,0) pixel.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mode_q <= 2'd0;
    end else if (frame_start) begin
      mode_q <= iMODE;
    end
  end

  // One-cycle pending stage: remembers that the freshly updated window must be emitted.
  logic          pend_q;
  logic          pend_border_q;
  logic [XW-1:0] pend_x_q;
  logic [YW-1:0] pend_y_q;

  // Record centre coordinates and border status of a qualifying accept.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pend_q        <= 1'b0;
      pend_border_q <= 1'b0;
      pend_x_q      <= '0;
      pend_y_q      <= '0;
    end else begin
      pend_q <= emit;
      if (emit) begin
        pend_x_q      <= iX_Cont - XW'(1);
        pend_y_q      <= iY_Cont - YW'(1);
        pend_border_q <= (iX_Cont == XW'(1)) || (iY_Cont == YW'(1));
      end
    end
  end

  function automatic logic signed [SW-1:0] ext(input logic [DW-1:0] p);
    ext = $signed({3'b000, p});
  endfunction

  logic signed [SW-1:0] gx;
  logic signed [SW-1:0] gy;
  logic        [SW-1:0] gx_abs;
  logic        [SW-1:0] gy_abs;
  logic        [SW:0]   mag;
  logic        [DW-1:0] data_d;

  assign gx = (ext(win_q[0][2]) + (ext(win_q[1][2]) <<< 1) + ext(win_q[2][2]))
            - (ext(win_q[0][0]) + (ext(win_q[1][0]) <<< 1) + ext(win_q[2][0]));
  assign gy = (ext(win_q[2][0]) + (ext(win_q[2][1]) <<< 1) + ext(win_q[2][2]))
            - (ext(win_q[0][0]) + (ext(win_q[0][1]) <<< 1) + ext(win_q[0][2]));

  assign gx_abs = gx[SW-1] ? -gx : gx;
  assign gy_abs = gy[SW-1] ? -gy : gy;

  // Select gradient magnitude per mode, saturate, and blank the border in filter modes.
  always_comb begin
    mag    = '0;
    data_d = '0;
    case (mode_q)
      2'd1:    mag = {1'b0, gx_abs};
      2'd2:    mag = {1'b0, gy_abs};
      2'd3:    mag = {1'b0, gx_abs} + {1'b0, gy_abs};
      default: mag = '0;
    endcase
    if (mode_q == 2'd0) begin
      data_d = win_q[1][1];
    end else if (pend_border_q) begin
      data_d = '0;
    end else if (mag > SAT_MAX) begin
      data_d = '1;
    end else begin
      data_d = mag[DW-1:0];
    end
  end

  logic [DW-1:0] data_q;
  logic          dval_q;
  logic [XW-1:0] x_q;
  logic [YW-1:0] y_q;

  // Registered outputs: pulse valid for one cycle, hold data/coords otherwise.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      data_q <= '0;
      dval_q <= 1'b0;
      x_q    <= '0;
      y_q    <= '0;
    end else begin
      dval_q <= pend_q;
      if (pend_q) begin
        data_q <= data_d;
        x_q    <= pend_x_q;
        y_q    <= pend_y_q;
      end
    end
  end

  assign oDATA   = data_q;
  assign oDVAL   = dval_q;
  assign oX_Cont = x_q;
  assign oY_Cont = y_q;
  assign oMODE   = mode_q;

endmodule

// File: tb/tb_img_filter_3x3.sv
// tb/tb_img_filter_3x3.sv - self-checking bench for img_filter_3x3
module tb_img_filter_3x3;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [7:0]  iDATA;
  logic        iDVAL;
  logic [11:0] iX_Cont;
  logic [15:0] iY_Cont;
  logic [1:0]  iMODE;
  logic [7:0]  oDATA;
  logic        oDVAL;
  logic [11:0] oX_Cont;
  logic [15:0] oY_Cont;
  logic [1:0]  oMODE;

  img_filter_3x3 #(.DW(8), .IMG_W(8), .XW(12), .YW(16)) dut (
    .clk(clk), .rst_n(rst_n), .iDATA(iDATA), .iDVAL(iDVAL),
    .iX_Cont(iX_Cont), .iY_Cont(iY_Cont), .iMODE(iMODE),
    .oDATA(oDATA), .oDVAL(oDVAL), .oX_Cont(oX_Cont), .oY_Cont(oY_Cont), .oMODE(oMODE)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d", name, act, exp);
    end
  endtask

  // Behavioural model: full image memory plus expected-output queue.
  typedef struct {int due; int d; int x; int y;} exp_t;
  exp_t q[$];
  int   img_m [0:7][0:7];
  int   out_img [0:7][0:7];
  int   mode_m  = 0;
  int   cyc     = 0;
  int   out_cnt = 0;
  int   last_d = 0, last_x = 0, last_y = 0;
  bit   started = 0;

  function automatic int iabs(input int v);
    return (v < 0) ? -v : v;
  endfunction

  function automatic int model_pix(input int cx, input int cy);
    int p [0:2][0:2];
    int gx, gy, m;
    if (mode_m == 0) return img_m[cy][cx];
    if (cx == 0 || cy == 0) return 0;
    for (int r = 0; r < 3; r++)
      for (int c = 0; c < 3; c++)
        p[r][c] = img_m[cy - 1 + r][cx - 1 + c];
    gx = (p[0][2] + 2 * p[1][2] + p[2][2]) - (p[0][0] + 2 * p[1][0] + p[2][0]);
    gy = (p[2][0] + 2 * p[2][1] + p[2][2]) - (p[0][0] + 2 * p[0][1] + p[0][2]);
    case (mode_m)
      1:       m = iabs(gx);
      2:       m = iabs(gy);
      default: m = iabs(gx) + iabs(gy);
    endcase
    return (m > 255) ? 255 : m;
  endfunction

  always @(posedge clk) begin
    cyc++;
    if (!rst_n) begin
      q.delete();
      mode_m = 0;
      last_d = 0; last_x = 0; last_y = 0;
    end else if (iDVAL && iX_Cont < 8) begin
      int x, y;
      exp_t e;
      x = int'(iX_Cont);
      y = int'(iY_Cont);
      if (x == 0 && y == 0) mode_m = int'(iMODE);
      img_m[y][x] = int'(iDATA);
      if (x >= 1 && y >= 1) begin
        e.due = cyc + 1;
        e.x   = x - 1;
        e.y   = y - 1;
        e.d   = model_pix(x - 1, y - 1);
        q.push_back(e);
      end
    end
  end

  always @(negedge clk) begin
    if (rst_n && started) begin
      if (q.size() > 0 && q[0].due == cyc) begin
        exp_t e;
        e = q.pop_front();
        check("dval_hi", int'(oDVAL), 1);
        check("data", int'(oDATA), e.d);
        check("xcont", int'(oX_Cont), e.x);
        check("ycont", int'(oY_Cont), e.y);
        last_d = e.d; last_x = e.x; last_y = e.y;
        out_img[e.y][e.x] = int'(oDATA);
        out_cnt++;
      end else begin
        check("dval_lo", int'(oDVAL), 0);
        check("data_hold", int'(oDATA), last_d);
        check("x_hold", int'(oX_Cont), last_x);
        check("y_hold", int'(oY_Cont), last_y);
      end
      check("mode", int'(oMODE), mode_m);
    end
  end

  function automatic int pix(input int kind, input int x, input int y);
    case (kind)
      0:       return 100;
      1:       return (x < 4) ? 0 : 255;
      2:       return 10 * x;
      default: return (x * 37 + y * 91 + 13) % 256;
    endcase
  endfunction

  task automatic drive(input int x, input int y, input int d);
    iDVAL   = 1'b1;
    iX_Cont = 12'(x);
    iY_Cont = 16'(y);
    iDATA   = 8'(d);
    @(posedge clk);
    #1;
    iDVAL = 1'b0;
  endtask

  task automatic idle(input int n);
    iDVAL = 1'b0;
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic run_frame(input int kind, input int mode, input int mode_mid,
                           input bit inj, input bit gaps, input int npix);
    out_cnt = 0;
    for (int y = 0; y < 6; y++) begin
      for (int x = 0; x < 8; x++) begin
        if (y * 8 + x >= npix) return;
        iMODE = 2'((y >= 3 && mode_mid >= 0) ? mode_mid : mode);
        drive(x, y, pix(kind, x, y));
        if (inj && (x % 3 == 1)) drive(8, y, int'($urandom_range(0, 255)));
        if (gaps && x == 5) idle(2);
      end
    end
    idle(3);
  endtask

  initial begin
    rst_n = 1'b0; iDATA = '0; iDVAL = 1'b0; iX_Cont = '0; iY_Cont = '0; iMODE = '0;
    @(posedge clk); #1;
    check("rst_dval", int'(oDVAL), 0);
    check("rst_data", int'(oDATA), 0);
    check("rst_x", int'(oX_Cont), 0);
    check("rst_y", int'(oY_Cont), 0);
    check("rst_mode", int'(oMODE), 0);
    repeat (2) @(posedge clk); #1;
    rst_n = 1'b1;
    started = 1;

    run_frame(0, 0, -1, 0, 0, 48);
    check("const_m0_cnt", out_cnt, 35);
    check("const_m0_23", out_img[2][3], 100);
    check("const_m0_46", out_img[4][6], 100);

    run_frame(0, 1, -1, 0, 0, 48);
    check("const_m1_cnt", out_cnt, 35);
    check("const_m1_23", out_img[2][3], 0);
    check("const_m1_00", out_img[0][0], 0);

    run_frame(1, 1, -1, 0, 0, 48);
    check("edge_m1_c3", out_img[2][3], 255);
    check("edge_m1_c4", out_img[2][4], 255);
    check("edge_m1_c5", out_img[2][5], 0);
    check("edge_m1_r0", out_img[0][3], 0);

    run_frame(1, 2, -1, 0, 0, 48);
    check("edge_m2_c3", out_img[2][3], 0);

    run_frame(2, 3, -1, 0, 1, 48);
    check("ramp_m3_cnt", out_cnt, 35);
    check("ramp_m3_23", out_img[2][3], 80);
    check("ramp_m3_r0", out_img[0][3], 80 * 0);
    check("ramp_m3_c0", out_img[2][0], 0);

    run_frame(2, 2, -1, 0, 0, 48);
    check("ramp_m2_23", out_img[2][3], 0);

    run_frame(3, 1, 0, 0, 0, 48);
    check("midmode_hold", int'(oMODE), 1);

    run_frame(3, 0, -1, 1, 0, 48);
    check("inj_cnt", out_cnt, 35);
    check("inj_newmode", int'(oMODE), 0);

    run_frame(2, 3, -1, 0, 0, 20);
    @(posedge clk); #1;
    check("pre_rst_dval", int'(oDVAL), 1);
    check("pre_rst_data", int'(oDATA), 80);
    #5;
    rst_n = 1'b0;
    #1;
    check("async_dval", int'(oDVAL), 0);
    check("async_data", int'(oDATA), 0);
    check("async_mode", int'(oMODE), 0);
    repeat (2) @(posedge clk); #1;
    rst_n = 1'b1;

    run_frame(0, 0, -1, 0, 0, 48);
    check("post_rst_cnt", out_cnt, 35);
    check("post_rst_23", out_img[2][3], 100);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
